// File: rtl/key_poll_master.sv
`default_nettype none
//==============================================================================
// Module : key_poll_master
// Brief  : Avalon-MM read initiator that polls a button PIO and debounces it
//          into level, press/release pulses and sticky press flags.
// Option : KEY_POLL_IRQ_EN adds irq_mask input and registered irq output.
// Rev    : 1.0  initial release
//==============================================================================
module key_poll_master #(
    parameter int WIDTH        = 4,
    parameter int POLL_DIV     = 50000,
    parameter int STABLE_CNT   = 3,
    parameter int READ_LATENCY = 1,
    parameter int ACTIVE_LOW   = 1,
    parameter int POLL_ADDR    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    input  logic             poll_enable,
    input  logic [WIDTH-1:0] sticky_clr,
`ifdef KEY_POLL_IRQ_EN
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] edge_sticky
);

    localparam int              c_tw        = $clog2(POLL_DIV);
    localparam logic [c_tw-1:0] c_poll_last = c_tw'(POLL_DIV - 1);
    localparam int              c_cw        = $clog2(STABLE_CNT + 1);
    localparam logic [c_cw-1:0] c_cnt_last  = c_cw'(STABLE_CNT - 1);
    localparam logic [1:0]      c_lat_last  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_lat  = 2'd2;

    logic [c_tw-1:0]  r_poll_cnt;
    logic             r_poll_pend;
    logic [1:0]       r_state;
    logic [1:0]       r_lat_cnt;
    logic [WIDTH-1:0] r_sticky;

    logic             w_tick;
    logic             w_take;
    logic             w_accept;
    logic             w_capture;
    logic [WIDTH-1:0] w_sample;

    assign avm_address = 2'(POLL_ADDR);
    assign avm_read    = (r_state == c_st_req);
    assign w_tick      = (r_poll_cnt == c_poll_last);
    assign w_take      = (r_state == c_st_idle) && r_poll_pend;
    assign w_accept    = (r_state == c_st_req) && !avm_waitrequest;
    assign w_sample    = (ACTIVE_LOW != 0) ? ~avm_readdata[WIDTH-1:0] : avm_readdata[WIDTH-1:0];

    // A new tick has priority over the take so it is not lost; extra ticks simply re-set the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_poll_cnt  <= '0;
            r_poll_pend <= 1'b0;
        end else if (!poll_enable) begin
            r_poll_cnt  <= '0;
            r_poll_pend <= 1'b0;
        end else begin
            if (w_tick) begin
                r_poll_cnt <= '0;
            end else begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end
            if (w_tick) begin
                r_poll_pend <= 1'b1;
            end else if (w_take) begin
                r_poll_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_st_idle;
            r_lat_cnt <= 2'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_poll_pend) begin
                        r_state <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (!avm_waitrequest) begin
                        r_lat_cnt <= 2'd0;
                        r_state   <= (READ_LATENCY == 0) ? c_st_idle : c_st_lat;
                    end
                end
                c_st_lat: begin
                    if (r_lat_cnt == c_lat_last) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_lat_zero
            assign w_capture = w_accept;
        end else begin : g_lat_fixed
            assign w_capture = (r_state == c_st_lat) && (r_lat_cnt == c_lat_last);
        end
    endgenerate

    // Each bit counts consecutive samples that disagree with its debounced level.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [c_cw-1:0] r_cnt;
            logic            r_level;
            logic            r_press;
            logic            r_release;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    if (w_capture) begin
                        if (w_sample[i] == r_level) begin
                            r_cnt <= '0;
                        end else if (r_cnt == c_cnt_last) begin
                            r_level   <= ~r_level;
                            r_cnt     <= '0;
                            r_press   <= ~r_level;
                            r_release <= r_level;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            end

            assign key_state[i]   = r_level;
            assign key_press[i]   = r_press;
            assign key_release[i] = r_release;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~sticky_clr) | key_press;
        end
    end

    assign edge_sticky = r_sticky;

`ifdef KEY_POLL_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_sticky & irq_mask);
        end
    end

    assign irq = r_irq;
`endif

    // Upper read-data bits carry no key information.
    generate
        if (WIDTH < 32) begin : g_hi_unused
            logic w_unused_hi;
            assign w_unused_hi = ^avm_readdata[31:WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_poll_master.sv
`default_nettype none
//==============================================================================
// Module : tb_key_poll_master
// Brief  : Scoreboard bench for key_poll_master with a sample-history model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_key_poll_master;

    localparam int WIDTH      = 4;
    localparam int POLL_DIV   = 8;
    localparam int STABLE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        poll_enable;
    logic [3:0]  sticky_clr;
    logic [3:0]  key_state;
    logic [3:0]  key_press;
    logic [3:0]  key_release;
    logic [3:0]  edge_sticky;
`ifdef KEY_POLL_IRQ_EN
    logic [3:0]  irq_mask;
    logic        irq;
`endif

    always #5 clk = ~clk;

    key_poll_master #(
        .WIDTH(WIDTH), .POLL_DIV(POLL_DIV), .STABLE_CNT(STABLE_CNT),
        .READ_LATENCY(1), .ACTIVE_LOW(1), .POLL_ADDR(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .poll_enable(poll_enable), .sticky_clr(sticky_clr),
`ifdef KEY_POLL_IRQ_EN
        .irq_mask(irq_mask), .irq(irq),
`endif
        .key_state(key_state), .key_press(key_press),
        .key_release(key_release), .edge_sticky(edge_sticky)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model: all captured samples plus index of each bit's last change.
    logic [3:0] smp_q[$];
    int         chg_idx[4];
    logic [3:0] m_state;

    // Stimulus controls
    logic [3:0] pins;
    bit en, rnd_pins, rnd_wr, rnd_clr, alt_mode, clr_on_press, mon_en, acc_prev;
    int stall_left, clr_plan;

    // Monitor state
    bit         acc_h1, acc_h2, after_acc, last_acc_v;
    logic [3:0] exp_state_cur, exp_sticky;
    bit         exp_irq;
    int         run_len, stall_cnt, cyc, last_acc, quiet;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // A bit flips when its last STABLE_CNT samples, all taken after its previous change, disagree with it.
    task automatic model_capture(input logic [3:0] p);
        logic [3:0] s, old;
        exp_t       e;
        int         n, idx;
        bit         ok;
        s = p ^ 4'hF;
        smp_q.push_back(s);
        n = smp_q.size() - 1;
        old = m_state;
        for (int i = 0; i < 4; i++) begin
            ok = 1'b1;
            for (int k = 0; k < STABLE_CNT; k++) begin
                idx = n - k;
                if (idx <= chg_idx[i]) ok = 1'b0;
                else if (smp_q[idx][i] == old[i]) ok = 1'b0;
            end
            if (ok) begin
                m_state[i] = ~old[i];
                chg_idx[i] = n;
            end
        end
        e.st = m_state;
        e.pr = m_state & ~old;
        e.rl = old & ~m_state;
        exp_q.push_back(e);
        if (e.pr[0] && clr_on_press) clr_plan = 2;
    endtask

    task automatic model_reset();
        m_state = 4'h0;
        smp_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) chg_idx[i] = -1;
    endtask

    // One clock of slave + stimulus, driven on the falling edge.
    task automatic step();
        @(negedge clk);
        poll_enable = en;
        if (avm_read && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else begin
            avm_waitrequest = rnd_wr ? ($urandom_range(3) == 0) : 1'b0;
        end
        if (clr_plan > 0) begin
            sticky_clr = 4'h1;
            clr_plan--;
        end else begin
            sticky_clr = (rnd_clr && $urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
        end
        avm_readdata = $urandom;
        if (acc_prev) begin
            avm_readdata[3:0] = pins;
            model_capture(pins);
            if (alt_mode) pins ^= 4'h1;
        end
        if (rnd_pins && $urandom_range(15) == 0) pins = 4'($urandom);
        #1;
        acc_prev = avm_read && !avm_waitrequest;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mon_clear();
        acc_h1 = 0; acc_h2 = 0; after_acc = 0; last_acc_v = 0;
        exp_state_cur = 4'h0; exp_sticky = 4'h0; exp_irq = 1'b0;
        run_len = 0; stall_cnt = 0; quiet = 0;
    endtask

    // Monitor: pops the scoreboard two cycles after each observed accept.
    initial begin
        exp_t       e;
        logic [3:0] ep;
        bit         acc;
        cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (mon_en) begin
                acc = avm_read && !avm_waitrequest;
                ep = 4'h0;
                if (acc_h2) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("key_state", 32'(key_state), 32'(e.st));
                        chk("key_press", 32'(key_press), 32'(e.pr));
                        chk("key_release", 32'(key_release), 32'(e.rl));
                        exp_state_cur = e.st;
                        ep = e.pr;
                    end
                end else begin
                    chk("state_hold", 32'(key_state), 32'(exp_state_cur));
                    chk("pulse_idle", 32'({key_press, key_release}), 32'd0);
                end
                chk("edge_sticky", 32'(edge_sticky), 32'(exp_sticky));
`ifdef KEY_POLL_IRQ_EN
                chk("irq", 32'(irq), 32'(exp_irq));
                exp_irq = |(exp_sticky & irq_mask);
`endif
                exp_sticky = (exp_sticky & ~sticky_clr) | ep;

                if (after_acc) chk("one_outstanding", 32'(avm_read), 32'd0);
                after_acc = 0;
                if (avm_read) begin
                    run_len++;
                    if (avm_waitrequest) stall_cnt++;
                end
                if (avm_waitrequest || !poll_enable) quiet = 0;
                else quiet++;
                if (acc) begin
                    chk("req_hold", 32'(run_len), 32'(stall_cnt + 1));
                    if (last_acc_v && quiet >= 20)
                        chk("poll_period", 32'(cyc - last_acc), 32'(POLL_DIV));
                    run_len = 0;
                    stall_cnt = 0;
                    after_acc = 1;
                    last_acc = cyc;
                    last_acc_v = 1;
                end
                acc_h2 = acc_h1;
                acc_h1 = acc;
            end
        end
    end

    initial begin
        int n, first_req;
        bit found;
        reset_n = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0;
        poll_enable = 1'b0;
        sticky_clr = 4'h0;
`ifdef KEY_POLL_IRQ_EN
        irq_mask = 4'h1;
`endif
        pins = 4'hF;
        en = 0; rnd_pins = 0; rnd_wr = 0; rnd_clr = 0; alt_mode = 0;
        clr_on_press = 0; mon_en = 0; acc_prev = 0; stall_left = 0; clr_plan = 0;
        model_reset();
        mon_clear();

        repeat (3) @(negedge clk);
        #1;
        chk("rst_avm_read", 32'(avm_read), 32'd0);
        chk("rst_address", 32'(avm_address), 32'd0);
        chk("rst_key_state", 32'(key_state), 32'd0);
        chk("rst_pulses", 32'({key_press, key_release}), 32'd0);
        chk("rst_sticky", 32'(edge_sticky), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1;
        en = 1;

        steps(40);                    // idle keys
        pins = 4'hE; steps(40);       // press bit 0
        pins = 4'hF; steps(40);       // release
        alt_mode = 1; pins = 4'hE; steps(80); alt_mode = 0;
        chk("glitch_reject", 32'(key_state), 32'd0);
        pins = 4'hF;

        stall_left = 5; steps(40);

        // Long stall: at most one tick may be queued while busy.
        stall_left = 20;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            found = acc_prev;
        end
        chk("stall_accept_seen", 32'(found), 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc_prev) n++;
        end
        chk("pend_max_one", 32'(n >= 1 && n <= 2), 32'd1);
        steps(20);

        clr_on_press = 1; pins = 4'hE; steps(40); clr_on_press = 0;
        pins = 4'h0; steps(40);

        rnd_pins = 1; rnd_wr = 1; rnd_clr = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(63) == 0) en = ~en;
            step();
        end
        rnd_pins = 0; rnd_wr = 0; rnd_clr = 0; en = 1;

        // Reset during the latency cycle of a read.
        pins = 4'h0; steps(40);
        en = 0; steps(6);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        mon_en = 0;
        en = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = acc_prev;
        end
        chk("pre_reset_accept", 32'(found), 32'd1);
        chk("pre_reset_state", 32'(key_state), 32'hF);
        @(negedge clk);
        reset_n = 1'b0;
        avm_readdata = 32'h0;
        #1;
        chk("lat_rst_avm_read", 32'(avm_read), 32'd0);
        chk("lat_rst_key_state", 32'(key_state), 32'd0);
        chk("lat_rst_pulses", 32'({key_press, key_release}), 32'd0);
        chk("lat_rst_sticky", 32'(edge_sticky), 32'd0);
`ifdef KEY_POLL_IRQ_EN
        chk("lat_rst_irq", 32'(irq), 32'd0);
`endif
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        mon_clear();
        acc_prev = 0;
        pins = 4'hF;
        mon_en = 1;
        first_req = 0;
        for (int i = 1; i <= 12 && first_req == 0; i++) begin
            step();
            if (avm_read) first_req = i;
        end
        chk("first_req_after_reset", 32'(first_req), 32'd9);
        pins = 4'hE; steps(40);
        steps(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
